// File: rtl/cdb_register_status.sv
// cdb_register_status: register file with producer-tag status table snooping the CDB and forwarding to two source lookups
module cdb_register_status #(
  parameter int DATA_W = 10,
  parameter int CNT_W = 8,
  parameter logic [DATA_W-1:0] R0_INIT = '0,
  parameter logic [DATA_W-1:0] R1_INIT = '0,
  parameter logic [DATA_W-1:0] R2_INIT = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [2:0]        issue_rd,
  input  logic [2:0]        issue_tag,
  input  logic [15:0]       cdb,
  input  logic [2:0]        src_a_idx,
  input  logic [2:0]        src_b_idx,
  output logic [DATA_W-1:0] src_a_value,
  output logic              src_a_ready,
  output logic [2:0]        src_a_tag,
  output logic [DATA_W-1:0] src_b_value,
  output logic              src_b_ready,
  output logic [2:0]        src_b_tag,
  output logic [DATA_W-1:0] R0_output,
  output logic [DATA_W-1:0] R1_output,
  output logic [DATA_W-1:0] R2_output,
  output logic [2:0]        busy,
  output logic [CNT_W-1:0]  commit_count,
  output logic [CNT_W-1:0]  stale_count
);
  logic [DATA_W-1:0] val [3];
  logic [2:0] tag_q [3];
  logic [2:0] cdb_tag, flag, cm, st, iss;
  logic [CNT_W-1:0] n_cm, n_st;
  logic va, vb;
  logic [1:0] ai, bi;
  logic [DATA_W-1:0] cdb_data;
  assign cdb_tag = {cdb[10], cdb[12:11]};
  assign cdb_data = cdb[DATA_W-1:0];
  for (genvar i = 0; i < 3; i++) begin : g_reg
    assign flag[i] = cdb[15-i];
    assign cm[i] = flag[i] && busy[i] && tag_q[i] == cdb_tag;
    assign st[i] = flag[i] && !cm[i];
    assign iss[i] = issue_valid && issue_rd == 3'(i);
  end
  assign n_cm = CNT_W'(cm[0]) + CNT_W'(cm[1]) + CNT_W'(cm[2]);
  assign n_st = CNT_W'(st[0]) + CNT_W'(st[1]) + CNT_W'(st[2]);
  always_ff @(posedge clock) begin
    if (!reset) begin
      val[0] <= R0_INIT;
      val[1] <= R1_INIT;
      val[2] <= R2_INIT;
      for (int i = 0; i < 3; i++) tag_q[i] <= '0;
      busy <= '0;
      commit_count <= '0;
      stale_count <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cm[i]) begin
          val[i] <= cdb_data;
          busy[i] <= 1'b0;
        end
        if (iss[i]) begin
          busy[i] <= 1'b1;
          tag_q[i] <= issue_tag;
        end
      end
      commit_count <= commit_count + n_cm;
      stale_count <= stale_count + n_st;
    end
  end
  assign R0_output = val[0];
  assign R1_output = val[1];
  assign R2_output = val[2];
  assign va = src_a_idx < 3'd3;
  assign vb = src_b_idx < 3'd3;
  assign ai = va ? src_a_idx[1:0] : 2'd0;
  assign bi = vb ? src_b_idx[1:0] : 2'd0;
  assign src_a_ready = !(va && busy[ai] && !cm[ai]);
  assign src_a_tag = src_a_ready ? 3'd0 : tag_q[ai];
  assign src_a_value = !va ? '0 : cm[ai] ? cdb_data : val[ai];
  assign src_b_ready = !(vb && busy[bi] && !cm[bi]);
  assign src_b_tag = src_b_ready ? 3'd0 : tag_q[bi];
  assign src_b_value = !vb ? '0 : cm[bi] ? cdb_data : val[bi];
endmodule

// File: tb/tb_cdb_register_status.sv
// tb_cdb_register_status: directed scoreboard bench for cdb_register_status
module tb_cdb_register_status;
  logic clock = 0, reset = 0, issue_valid = 0;
  logic [2:0] issue_rd = 0, issue_tag = 0, src_a_idx = 0, src_b_idx = 0;
  logic [15:0] cdb = 0;
  logic [9:0] src_a_value, src_b_value, R0_output, R1_output, R2_output;
  logic src_a_ready, src_b_ready;
  logic [2:0] src_a_tag, src_b_tag, busy;
  logic [7:0] commit_count, stale_count;
  int vectors = 0, miscompares = 0;
  typedef struct {string name; int field; logic [15:0] exp;} chk_t;
  chk_t q[$];
  cdb_register_status dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_tag(issue_tag), .cdb(cdb), .src_a_idx(src_a_idx), .src_b_idx(src_b_idx),
    .src_a_value(src_a_value), .src_a_ready(src_a_ready), .src_a_tag(src_a_tag),
    .src_b_value(src_b_value), .src_b_ready(src_b_ready), .src_b_tag(src_b_tag),
    .R0_output(R0_output), .R1_output(R1_output), .R2_output(R2_output), .busy(busy),
    .commit_count(commit_count), .stale_count(stale_count)
  );
  always #5 clock = ~clock;
  localparam int AV = 0, AR = 1, AT = 2, BV = 3, BR = 4, BT = 5, R0 = 6, R1 = 7, R2 = 8, BS = 9, CC = 10, SC = 11;
  function automatic logic [15:0] get(input int f);
    case (f)
      AV: return 16'(src_a_value);
      AR: return 16'(src_a_ready);
      AT: return 16'(src_a_tag);
      BV: return 16'(src_b_value);
      BR: return 16'(src_b_ready);
      BT: return 16'(src_b_tag);
      R0: return 16'(R0_output);
      R1: return 16'(R1_output);
      R2: return 16'(R2_output);
      BS: return 16'(busy);
      CC: return 16'(commit_count);
      default: return 16'(stale_count);
    endcase
  endfunction
  function automatic logic [15:0] mk(input logic [2:0] f, input logic [2:0] t, input logic [9:0] d);
    return {f, t[1:0], t[2], d};
  endfunction
  always @(negedge clock) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [15:0] act;
      c = q.pop_front();
      act = get(c.field);
      vectors++;
      if (act !== c.exp) begin
        miscompares++;
        $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
      end
    end
  end
  task automatic expect_v(input string n, input int f, input logic [15:0] e);
    q.push_back('{n, f, e});
  endtask
  task automatic step(input logic r, input logic iv, input logic [2:0] rd, input logic [2:0] it,
                      input logic [15:0] c, input logic [2:0] a, input logic [2:0] b);
    @(posedge clock);
    #1;
    reset = r; issue_valid = iv; issue_rd = rd; issue_tag = it; cdb = c; src_a_idx = a; src_b_idx = b;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clock);
    step(0, 1, 0, 3'b111, mk(3'b111, 3'b111, 10'd3), 0, 5);
    expect_v("rst_r0", R0, 0); expect_v("rst_r1", R1, 0); expect_v("rst_r2", R2, 0);
    expect_v("rst_busy", BS, 0); expect_v("rst_cc", CC, 0); expect_v("rst_sc", SC, 0);
    step(1, 0, 0, 0, 0, 0, 5);
    expect_v("rst_ignores_in_busy", BS, 0); expect_v("rst_ignores_in_sc", SC, 0);
    expect_v("rst_ignores_in_cc", CC, 0);
    expect_v("a_idle_val", AV, 0); expect_v("a_idle_rdy", AR, 1); expect_v("a_idle_tag", AT, 0);
    expect_v("b_oob_val", BV, 0); expect_v("b_oob_rdy", BR, 1); expect_v("b_oob_tag", BT, 0);
    step(1, 1, 1, 3'b101, 0, 1, 0);
    expect_v("pre_issue_busy", BS, 0); expect_v("pre_issue_lookup_rdy", AR, 1);
    step(1, 0, 0, 0, 16'h2800 | 16'd42, 1, 0);
    expect_v("r1_pending_busy", BS, 3'b010); expect_v("r1_pending_rdy", AR, 0);
    expect_v("r1_pending_tag", AT, 3'b101); expect_v("r1_pending_sc", SC, 0);
    step(1, 1, 2, 3'b110, 0, 0, 0);
    expect_v("stale1_sc", SC, 1); expect_v("stale1_busy", BS, 3'b010); expect_v("stale1_r1", R1, 0);
    step(1, 0, 0, 0, mk(3'b001, 3'b110, 10'd77), 2, 1);
    expect_v("r2_busy", BS, 3'b110); expect_v("fwd_r2_val", AV, 77); expect_v("fwd_r2_rdy", AR, 1);
    expect_v("fwd_r2_tag", AT, 0); expect_v("b_r1_rdy", BR, 0); expect_v("b_r1_tag", BT, 3'b101);
    step(1, 0, 0, 0, 0, 0, 0);
    expect_v("commit_r2", R2, 77); expect_v("commit_r2_busy", BS, 3'b010);
    expect_v("commit_r2_cc", CC, 1); expect_v("commit_r2_sc", SC, 1);
    step(1, 1, 0, 3'b001, 0, 0, 0);
    step(1, 1, 0, 3'b010, 0, 0, 0);
    expect_v("waw_busy", BS, 3'b011);
    step(1, 0, 0, 0, mk(3'b100, 3'b001, 10'd5), 0, 0);
    expect_v("old_tag_rdy", AR, 0); expect_v("old_tag_tag", AT, 3'b010); expect_v("old_tag_val", AV, 0);
    step(1, 0, 0, 0, mk(3'b100, 3'b010, 10'd9), 0, 0);
    expect_v("waw_stale_sc", SC, 2); expect_v("waw_stale_r0", R0, 0); expect_v("waw_stale_busy", BS, 3'b011);
    expect_v("fwd_r0_val", AV, 9); expect_v("fwd_r0_rdy", AR, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    expect_v("commit_r0", R0, 9); expect_v("commit_r0_busy", BS, 3'b010); expect_v("commit_r0_cc", CC, 2);
    step(1, 1, 1, 3'b111, mk(3'b010, 3'b101, 10'd12), 1, 0);
    expect_v("same_cyc_fwd_val", AV, 12); expect_v("same_cyc_fwd_rdy", AR, 1);
    step(1, 0, 0, 0, 0, 1, 0);
    expect_v("same_cyc_r1", R1, 12); expect_v("same_cyc_busy", BS, 3'b010); expect_v("same_cyc_cc", CC, 3);
    expect_v("same_cyc_rdy", AR, 0); expect_v("same_cyc_tag", AT, 3'b111); expect_v("same_cyc_val", AV, 12);
    step(1, 1, 0, 3'b111, 0, 0, 0);
    step(1, 0, 0, 0, mk(3'b110, 3'b111, 10'd300), 0, 1);
    expect_v("dual_busy", BS, 3'b011); expect_v("dual_a_val", AV, 300); expect_v("dual_a_rdy", AR, 1);
    expect_v("dual_b_val", BV, 300); expect_v("dual_b_rdy", BR, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    expect_v("dual_r0", R0, 300); expect_v("dual_r1", R1, 300); expect_v("dual_busy_clr", BS, 0);
    expect_v("dual_cc", CC, 5); expect_v("dual_sc", SC, 2);
    step(1, 1, 2, 3'b011, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    expect_v("pre_midrst_busy", BS, 3'b100);
    step(1, 0, 0, 0, mk(3'b001, 3'b011, 10'd55), 2, 0);
    expect_v("midrst_busy", BS, 0); expect_v("midrst_r0", R0, 0); expect_v("midrst_r1", R1, 0);
    expect_v("midrst_r2", R2, 0); expect_v("midrst_cc", CC, 0); expect_v("midrst_sc", SC, 0);
    expect_v("midrst_a_val", AV, 0); expect_v("midrst_a_rdy", AR, 1); expect_v("midrst_a_tag", AT, 0);
    step(1, 1, 3, 3'b101, 0, 0, 0);
    expect_v("late_sc", SC, 1); expect_v("late_cc", CC, 0); expect_v("late_r2", R2, 0);
    step(1, 0, 0, 0, mk(3'b111, 3'b000, 10'd1), 0, 0);
    expect_v("rd3_ignored_busy", BS, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    expect_v("multi_stale_sc", SC, 4); expect_v("multi_stale_cc", CC, 0);
    @(negedge clock);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
